// File: rtl/bip_control_unit_if.sv
// ---------------------------------------------------------------------------
// bip_control_unit_if
//   Bundles the sequencer's control, program-memory and datapath-strobe
//   signals so they can be passed as one port.
//   master : the sequencer side (drives address, strobes, status)
//   slave  : the environment side (drives start/enable and memory data)
//   Signals:
//     i_start, i_enable   run control from the debug unit
//     o_pm_addr/i_pm_data program_memory address / read data
//     o_operand, o_sel_a, o_sel_b, o_op, o_wr_acc, o_wr_ram, o_rd_ram
//                         decoded controls for the accumulator/ALU/data RAM
//     o_halted, o_cycle_cnt, o_instr_cnt   status for the debug unit
// ---------------------------------------------------------------------------
interface bip_control_unit_if #(
  parameter int B     = 16,
  parameter int W     = 11,
  parameter int CNT_W = 32
);
  logic             i_start;
  logic             i_enable;
  logic [W-1:0]     o_pm_addr;
  logic [B-1:0]     i_pm_data;
  logic [W-1:0]     o_operand;
  logic [1:0]       o_sel_a;
  logic             o_sel_b;
  logic             o_op;
  logic             o_wr_acc;
  logic             o_wr_ram;
  logic             o_rd_ram;
  logic             o_halted;
  logic [CNT_W-1:0] o_cycle_cnt;
  logic [CNT_W-1:0] o_instr_cnt;

  modport master (
    input  i_start, i_enable, i_pm_data,
    output o_pm_addr, o_operand, o_sel_a, o_sel_b, o_op,
           o_wr_acc, o_wr_ram, o_rd_ram, o_halted, o_cycle_cnt, o_instr_cnt
  );

  modport slave (
    output i_start, i_enable, i_pm_data,
    input  o_pm_addr, o_operand, o_sel_a, o_sel_b, o_op,
           o_wr_acc, o_wr_ram, o_rd_ram, o_halted, o_cycle_cnt, o_instr_cnt
  );
endinterface

// File: rtl/bip_control_unit.sv
// ---------------------------------------------------------------------------
// bip_control_unit
//   Instruction sequencer for the BIP processor. Owns the PC, addresses the
//   synchronous-read program memory, decodes each returned word into
//   single-cycle datapath strobes, and keeps halt/cycle/instruction status.
//   Ports:
//     clk      system clock (rising edge)
//     i_rst_n  asynchronous active-low reset
//     bus      bip_control_unit_if.master (start/enable, memory, strobes,
//              status)
//   Each instruction takes a FETCH cycle (address presented) and an EXEC
//   cycle (memory data valid, strobes asserted).
// ---------------------------------------------------------------------------
module bip_control_unit #(
  parameter int B     = 16,
  parameter int W     = 11,
  parameter int OPC_W = 5,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   i_rst_n,
  bip_control_unit_if.master     bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam logic [OPC_W-1:0] OP_HLT  = 5'd0;
  localparam logic [OPC_W-1:0] OP_STO  = 5'd1;
  localparam logic [OPC_W-1:0] OP_LD   = 5'd2;
  localparam logic [OPC_W-1:0] OP_LDI  = 5'd3;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'd4;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'd5;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'd6;
  localparam logic [OPC_W-1:0] OP_SUBI = 5'd7;

  state_e           state_q, state_d;
  logic [W-1:0]     pc_q, pc_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

  logic [OPC_W-1:0] opcode_s;
  logic [W-1:0]     operand_s;
  logic [1:0]       sel_a_s;
  logic             sel_b_s;
  logic             op_s;
  logic             wr_acc_s;
  logic             wr_ram_s;
  logic             rd_ram_s;

  assign opcode_s = bus.i_pm_data[B-1 -: OPC_W];

  // State register: FSM state, PC and debug counters.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  // Next-state, PC/counter update and instruction decode.
  // With i_enable low nothing advances and all decode outputs stay 0, so a
  // frozen EXEC simply replays once enable returns (memory address is held).
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    operand_s   = '0;
    sel_a_s     = 2'd0;
    sel_b_s     = 1'b0;
    op_s        = 1'b0;
    wr_acc_s    = 1'b0;
    wr_ram_s    = 1'b0;
    rd_ram_s    = 1'b0;

    if (state_q == ST_EXEC) begin
      operand_s = bus.i_pm_data[W-1:0];
    end else begin
      operand_s = '0;
    end

    if (bus.i_enable) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.i_start) begin
            state_d = ST_FETCH;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_FETCH: begin
          cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
          state_d     = ST_EXEC;
        end
        ST_EXEC: begin
          cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
          instr_cnt_d = instr_cnt_q + CNT_W'(1);
          case (opcode_s)
            OP_STO:  wr_ram_s = 1'b1;
            OP_LD: begin
              rd_ram_s = 1'b1;
              wr_acc_s = 1'b1;
            end
            OP_LDI: begin
              sel_a_s  = 2'd1;
              wr_acc_s = 1'b1;
            end
            OP_ADD: begin
              rd_ram_s = 1'b1;
              sel_a_s  = 2'd2;
              wr_acc_s = 1'b1;
            end
            OP_ADDI: begin
              sel_a_s  = 2'd2;
              sel_b_s  = 1'b1;
              wr_acc_s = 1'b1;
            end
            OP_SUB: begin
              rd_ram_s = 1'b1;
              sel_a_s  = 2'd2;
              op_s     = 1'b1;
              wr_acc_s = 1'b1;
            end
            OP_SUBI: begin
              sel_a_s  = 2'd2;
              sel_b_s  = 1'b1;
              op_s     = 1'b1;
              wr_acc_s = 1'b1;
            end
            default: begin
              // HLT and unassigned opcodes (NOP) drive no strobes.
              wr_acc_s = 1'b0;
            end
          endcase
          if (opcode_s == OP_HLT) begin
            state_d = ST_HALT;
          end else begin
            pc_d    = pc_q + W'(1);   // wraps modulo 2^W
            state_d = ST_FETCH;
          end
        end
        ST_HALT: begin
          state_d = ST_HALT;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  assign bus.o_pm_addr   = pc_q;
  assign bus.o_operand   = operand_s;
  assign bus.o_sel_a     = sel_a_s;
  assign bus.o_sel_b     = sel_b_s;
  assign bus.o_op        = op_s;
  assign bus.o_wr_acc    = wr_acc_s;
  assign bus.o_wr_ram    = wr_ram_s;
  assign bus.o_rd_ram    = rd_ram_s;
  assign bus.o_halted    = (state_q == ST_HALT);
  assign bus.o_cycle_cnt = cycle_cnt_q;
  assign bus.o_instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_bip_control_unit.sv
// ---------------------------------------------------------------------------
// tb_bip_control_unit
//   Directed, table-driven bench for bip_control_unit with a behavioural
//   synchronous-read program memory.
// ---------------------------------------------------------------------------
module tb_bip_control_unit;

  logic clk;
  logic rst_n;

  bip_control_unit_if #(.B(16), .W(11), .CNT_W(32)) bus ();

  bip_control_unit #(.B(16), .W(11), .OPC_W(5), .CNT_W(32)) dut (
    .clk     (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program memory, one-cycle read latency.
  logic [15:0] mem [0:2047];
  always @(posedge clk) bus.i_pm_data <= mem[bus.o_pm_addr];

  int chk_cnt;
  int pass_cnt;

  // Decode bundle: {sel_a[1:0], sel_b, op, wr_acc, wr_ram, rd_ram}
  function automatic logic [6:0] mk(input logic [1:0] sa, input logic sb, input logic op,
                                    input logic acc, input logic wr, input logic rd);
    return {sa, sb, op, acc, wr, rd};
  endfunction

  function automatic logic [6:0] dec_now();
    return {bus.o_sel_a, bus.o_sel_b, bus.o_op, bus.o_wr_acc, bus.o_wr_ram, bus.o_rd_ram};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.i_start = 1'b0;
    bus.i_enable = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic pulse_start();
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [15:0] instr;
    logic [6:0]  dec;
    logic [10:0] opnd;
  } vec_t;

  vec_t vecs [9];
  localparam int NV = 9;

  logic [6:0] basic_dec [4];
  logic [10:0] basic_opnd [4];
  int bad;

  initial begin
    chk_cnt = 0;
    pass_cnt = 0;
    rst_n = 1'b0;
    bus.i_start = 1'b0;
    bus.i_enable = 1'b1;

    vecs[0] = '{"LDI",  16'h1805, mk(2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 11'd5};
    vecs[1] = '{"ADDI", 16'h2803, mk(2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), 11'd3};
    vecs[2] = '{"STO",  16'h0807, mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), 11'd7};
    vecs[3] = '{"LD",   16'h1009, mk(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1), 11'd9};
    vecs[4] = '{"ADD",  16'h200A, mk(2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1), 11'd10};
    vecs[5] = '{"SUB",  16'h300B, mk(2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1), 11'd11};
    vecs[6] = '{"SUBI", 16'h3FFF, mk(2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), 11'h7FF};
    vecs[7] = '{"NOP8", 16'h4123, mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 11'h123};
    vecs[8] = '{"NOP31",16'hF800, mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 11'd0};

    for (int a = 0; a < 2048; a++) mem[a] = 16'h0000;

    // ---------------- Reset mid-EXEC, then idle without start -------------
    mem[0] = 16'h1805; mem[1] = 16'h2803; mem[2] = 16'h0807; mem[3] = 16'h0000;
    do_reset();
    pulse_start();            // FETCH 0
    step();                   // EXEC 0
    step();                   // FETCH 1
    step();                   // EXEC 1 (ADDI)
    chk("pre_reset_wr_acc", 32'(bus.o_wr_acc), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_addr", 32'(bus.o_pm_addr), 32'd0);
    chk("async_rst_dec", 32'(dec_now()), 32'd0);
    chk("async_rst_cyc", bus.o_cycle_cnt, 32'd0);
    step();
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus.o_pm_addr !== 11'd0 || dec_now() !== 7'd0 || bus.o_cycle_cnt !== 32'd0 ||
          bus.o_instr_cnt !== 32'd0 || bus.o_halted !== 1'b0 || bus.o_operand !== 11'd0)
        bad++;
    end
    chk("idle_10_cycles_bad", 32'(bad), 32'd0);

    // ---------------- Basic program with i_start pulses while running -----
    basic_dec[0] = mk(2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); basic_opnd[0] = 11'd5;
    basic_dec[1] = mk(2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); basic_opnd[1] = 11'd3;
    basic_dec[2] = mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); basic_opnd[2] = 11'd7;
    basic_dec[3] = 7'd0;                                    basic_opnd[3] = 11'd0;
    pulse_start();
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("basic_addr_%0d", j), 32'(bus.o_pm_addr), 32'(j / 2));
      if (j % 2 == 1) begin
        chk($sformatf("basic_dec_%0d", j / 2), 32'(dec_now()), 32'(basic_dec[j / 2]));
        chk($sformatf("basic_opnd_%0d", j / 2), 32'(bus.o_operand), 32'(basic_opnd[j / 2]));
      end else begin
        chk($sformatf("basic_fetch_dec_%0d", j / 2), 32'(dec_now()), 32'd0);
      end
      bus.i_start = (j == 2 || j == 3);   // ignored in FETCH and EXEC
      step();
      bus.i_start = 1'b0;
    end
    chk("basic_halted", 32'(bus.o_halted), 32'd1);
    chk("basic_instr_cnt", bus.o_instr_cnt, 32'd4);
    chk("basic_cycle_cnt", bus.o_cycle_cnt, 32'd8);
    chk("basic_pc", 32'(bus.o_pm_addr), 32'd3);
    pulse_start();                       // ignored in HALT
    step();
    chk("halt_start_halted", 32'(bus.o_halted), 32'd1);
    chk("halt_start_pc", 32'(bus.o_pm_addr), 32'd3);
    chk("halt_cycle_frozen", bus.o_cycle_cnt, 32'd8);
    chk("halt_dec", 32'(dec_now()), 32'd0);

    // ---------------- Decode table ---------------------------------------
    for (int i = 0; i < NV; i++) mem[i] = vecs[i].instr;
    mem[NV] = 16'h0000;
    do_reset();
    pulse_start();
    for (int i = 0; i < NV; i++) begin
      chk({"fetch_dec_", vecs[i].name}, 32'(dec_now()), 32'd0);
      chk({"fetch_addr_", vecs[i].name}, 32'(bus.o_pm_addr), 32'(i));
      step();
      chk({"dec_", vecs[i].name}, 32'(dec_now()), 32'(vecs[i].dec));
      chk({"opnd_", vecs[i].name}, 32'(bus.o_operand), 32'(vecs[i].opnd));
      step();
    end
    step();                                  // EXEC of HLT
    chk("hlt_dec", 32'(dec_now()), 32'd0);
    chk("hlt_not_yet_halted", 32'(bus.o_halted), 32'd0);
    step();
    chk("tbl_halted", 32'(bus.o_halted), 32'd1);
    chk("tbl_instr_cnt", bus.o_instr_cnt, 32'(NV + 1));
    chk("tbl_cycle_cnt", bus.o_cycle_cnt, 32'(2 * (NV + 1)));
    chk("tbl_pc", 32'(bus.o_pm_addr), 32'(NV));

    // ---------------- Enable freeze during ADDI EXEC ---------------------
    mem[0] = 16'h1805; mem[1] = 16'h2803; mem[2] = 16'h0000;
    do_reset();
    pulse_start();
    step(); step(); step();                  // EXEC of ADDI
    bus.i_enable = 1'b0;
    #1;
    chk("frz_dec_0", 32'(dec_now()), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("frz_dec_%0d", k + 1), 32'(dec_now()), 32'd0);
      chk($sformatf("frz_addr_%0d", k + 1), 32'(bus.o_pm_addr), 32'd1);
      chk($sformatf("frz_icnt_%0d", k + 1), bus.o_instr_cnt, 32'd1);
    end
    bus.i_enable = 1'b1;
    #1;
    chk("frz_addi_dec", 32'(dec_now()), 32'(mk(2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0)));
    chk("frz_addi_opnd", 32'(bus.o_operand), 32'd3);
    step();
    chk("frz_after_dec", 32'(dec_now()), 32'd0);
    chk("frz_after_addr", 32'(bus.o_pm_addr), 32'd2);
    chk("frz_after_icnt", bus.o_instr_cnt, 32'd2);
    step(); step();
    chk("frz_halted", 32'(bus.o_halted), 32'd1);
    chk("frz_final_icnt", bus.o_instr_cnt, 32'd3);
    chk("frz_final_cyc", bus.o_cycle_cnt, 32'd6);

    // ---------------- PC wrap with unassigned opcode ---------------------
    for (int a = 0; a < 2048; a++) mem[a] = 16'hF800;
    do_reset();
    pulse_start();
    bad = 0;
    for (int k = 0; k < 4096; k++) begin
      if (bus.o_pm_addr !== 11'(k / 2) || dec_now() !== 7'd0) bad++;
      step();
    end
    chk("wrap_bad_cycles", 32'(bad), 32'd0);
    chk("wrap_pc", 32'(bus.o_pm_addr), 32'd0);
    chk("wrap_instr_cnt", bus.o_instr_cnt, 32'd2048);
    chk("wrap_cycle_cnt", bus.o_cycle_cnt, 32'd4096);
    chk("wrap_not_halted", 32'(bus.o_halted), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/bip_control_unit.md
Name: bip_control_unit

Overview:
- Instruction sequencer for the BIP-style processor. It owns the program counter and drives the address of the synchronous-read program_memory (B=16, W=11, one-cycle read latency).
- It decodes each returned instruction word (opcode = data[15:11], operand = data[10:0]) into single-cycle control strobes for the accumulator/ALU datapath and data memory.
- It also keeps a halt state and cycle/instruction counters for the debug unit.

Parameters:
- B, 16: instruction word width.
- W, 11: program address width (PC width); also the operand width.
- OPC_W, 5: opcode width; opcode = i_pm_data[B-1 -: OPC_W].
- CNT_W, 32: width of the cycle and instruction counters.

Ports:
- clk  in  1  system clock, all state on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle pulse; leaves IDLE and begins fetch at PC=0.
- i_enable  in  1  step/run gate from the debug unit; when 0, all state frozen.
- o_pm_addr  out  W  address to program_memory; equals PC.
- i_pm_data  in  B  program_memory data; valid the cycle after o_pm_addr is stable.
- o_operand  out  W  i_pm_data[W-1:0], passed through during EXEC, else 0.
- o_sel_a  out  2  accumulator source: 0=data RAM, 1=immediate, 2=ALU.
- o_sel_b  out  1  ALU B operand: 0=data RAM, 1=immediate.
- o_op  out  1  ALU op: 0=add, 1=sub.
- o_wr_acc  out  1  accumulator write strobe.
- o_wr_ram  out  1  data-RAM write strobe.
- o_rd_ram  out  1  data-RAM read strobe.
- o_halted  out  1  high while in HALT.
- o_cycle_cnt  out  CNT_W  clocks elapsed since leaving IDLE, while enabled and not halted.
- o_instr_cnt  out  CNT_W  instructions executed, including HLT.

Behaviour:
- Reset (asynchronous, on i_rst_n=0, mid-operation included):
  - state=IDLE, PC=0, both counters=0, o_halted=0.
  - All strobes 0, o_sel_a=0, o_sel_b=0, o_op=0, o_operand=0.
  - Release is synchronous to the next clk edge.
- States: IDLE, FETCH, EXEC, HALT.
  - IDLE: o_pm_addr=0. Goes to FETCH on i_start=1 and i_enable=1. i_start is ignored in all other states.
  - FETCH: o_pm_addr=PC; all strobes 0. Goes to EXEC next cycle.
  - EXEC: decode i_pm_data combinationally; strobes are valid for exactly this cycle. o_instr_cnt += 1.
    - If opcode==HLT: go to HALT; PC unchanged.
    - Otherwise: PC <= PC+1, wrapping modulo 2^W (2047 -> 0); go to FETCH.
  - HALT: all strobes 0, o_halted=1. Exits only via reset. o_cycle_cnt stops.
- Throughput: 2 clocks per instruction. Latency from i_start to first EXEC: 2 clocks.
- Decode (outputs not listed are 0):
  - 00000 HLT: none.
  - 00001 STO: wr_ram.
  - 00010 LD: rd_ram, sel_a=0, wr_acc.
  - 00011 LDI: sel_a=1, wr_acc.
  - 00100 ADD: rd_ram, sel_a=2, sel_b=0, op=0, wr_acc.
  - 00101 ADDI: sel_a=2, sel_b=1, op=0, wr_acc.
  - 00110 SUB: rd_ram, sel_a=2, sel_b=0, op=1, wr_acc.
  - 00111 SUBI: sel_a=2, sel_b=1, op=1, wr_acc.
  - Opcodes 01000–11111: treated as NOP — no strobes, PC increments, o_instr_cnt increments.
- i_enable=0 (any state):
  - State, PC, counters and o_pm_addr hold.
  - All strobes forced to 0.
  - An EXEC cycle with i_enable=0 is not consumed: the same instruction executes on the first enabled cycle. program_memory keeps its output because its address is held.
- Counters: o_cycle_cnt += 1 on every enabled clock in FETCH or EXEC. Both counters wrap at 2^CNT_W.
- o_pm_addr is driven from the PC register (glitch-free); decode outputs are combinational from i_pm_data and state.

Test Plan:
- Reset/idle: assert i_rst_n=0 mid-EXEC, then release without i_start -> state IDLE, o_pm_addr=0, all strobes 0, counters 0 for 10 cycles.
- Basic program: memory {0:LDI 5 (0x1805), 1:ADDI 3 (0x2803), 2:STO 7 (0x0807), 3:HLT (0x0000)}, then pulse i_start ->
  - o_pm_addr sequence 0,0,1,1,2,2,3,3.
  - EXEC strobes: LDI(sel_a=1, wr_acc, operand=5); ADDI(sel_a=2, sel_b=1, op=0, operand=3); STO(wr_ram, operand=7).
  - Final: o_halted=1, o_instr_cnt=4, o_cycle_cnt=8, PC=3.
- SUB/LD/ADD/SUBI decode: one of each -> strobe patterns exactly per the decode table; o_rd_ram=1 only for LD/ADD/SUB.
- Enable freeze: drop i_enable for 3 cycles during EXEC of ADDI -> strobes 0 during the freeze; ADDI strobes appear once after re-enable; o_instr_cnt increments once.
- Wrap and illegal opcode: preload PC path by filling addresses 0–2047 with opcode 0x1F (0xF800) -> no strobes ever; PC wraps 2047->0; o_instr_cnt=2048 after 4096 cycles.
- i_start while running: pulse i_start in FETCH/EXEC/HALT -> no effect on PC or state.
